// File: rtl/divider_sequencer.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU with
// start/busy/result_valid handshake and RISC-V special-case handling.
module divider_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      alu_function,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  // state | meaning
  // IDLE  | waiting for a divide start
  // CALC  | one quotient bit per cycle
  // DONE  | result_valid pulse, back to IDLE next edge
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam logic [4:0] ALU_DIV  = 5'b10100;
  localparam logic [4:0] ALU_DIVU = 5'b10101;
  localparam logic [4:0] ALU_REM  = 5'b10110;
  localparam logic [4:0] ALU_REMU = 5'b10111;

  localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic              is_rem_q, is_rem_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   quot_q, quot_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   dvsr_q, dvsr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_div_op, op_signed, op_rem;
  logic              a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     shifted, diff;
  logic              no_borrow;
  logic [XLEN-1:0]   rem_next, quot_next;

  assign is_div_op = (alu_function == ALU_DIV) || (alu_function == ALU_DIVU) ||
                     (alu_function == ALU_REM) || (alu_function == ALU_REMU);
  assign op_signed = (alu_function == ALU_DIV) || (alu_function == ALU_REM);
  assign op_rem    = (alu_function == ALU_REM) || (alu_function == ALU_REMU);
  assign a_neg     = op_signed & operand_a[XLEN-1];
  assign b_neg     = op_signed & operand_b[XLEN-1];
  assign a_mag     = a_neg ? -operand_a : operand_a;
  assign b_mag     = b_neg ? -operand_b : operand_b;
  assign div_zero  = (operand_b == '0);
  assign ovf       = op_signed && (operand_a == SMIN) && (operand_b == '1);

  // Remainder stays below the divisor, so XLEN+1 bits hold the shifted value
  // and the top bit of the difference is the borrow.
  assign shifted   = {rem_q, quot_q[XLEN-1]};
  assign diff      = shifted - {1'b0, dvsr_q};
  assign no_borrow = ~diff[XLEN];
  assign rem_next  = no_borrow ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quot_next = {quot_q[XLEN-2:0], no_borrow};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      is_rem_q <= 1'b0;
      neg_q    <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      is_rem_q <= is_rem_d;
      neg_q    <= neg_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    is_rem_d = is_rem_q;
    neg_d    = neg_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush && is_div_op) begin
          is_rem_d = op_rem;
          if (div_zero) begin
            result_d = op_rem ? operand_a : '1;
            state_d  = S_DONE;
          end else if (ovf) begin
            result_d = op_rem ? '0 : operand_a;
            state_d  = S_DONE;
          end else begin
            neg_d   = op_rem ? a_neg : (a_neg ^ b_neg);
            quot_d  = a_mag;
            dvsr_d  = b_mag;
            rem_d   = '0;
            cnt_d   = CNT_W'(XLEN-1);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          quot_d = quot_next;
          rem_d  = rem_next;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            cnt_d   = '0;
            state_d = S_DONE;
            if (is_rem_q) result_d = neg_q ? -rem_next : rem_next;
            else          result_d = neg_q ? -quot_next : quot_next;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != S_IDLE);
    result_valid = (state_q == S_DONE);
    result       = result_q;
  end

endmodule

// File: tb/tb_divider_sequencer.sv
// Self-checking bench for divider_sequencer: directed cases plus randomized
// operations checked against an arithmetic reference model.
module tb_divider_sequencer;

  localparam int XLEN = 32;
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_DIV  = 5'b10100;
  localparam logic [4:0] ALU_DIVU = 5'b10101;
  localparam logic [4:0] ALU_REM  = 5'b10110;
  localparam logic [4:0] ALU_REMU = 5'b10111;
  localparam logic [31:0] SMIN = 32'h8000_0000;

  logic            clock = 1'b0;
  logic            reset;
  logic            start;
  logic [4:0]      alu_function;
  logic [XLEN-1:0] operand_a, operand_b;
  logic            flush;
  logic            busy, result_valid;
  logic [XLEN-1:0] result;

  int n_cmp = 0;
  int n_err = 0;

  divider_sequencer #(.XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .start(start), .alu_function(alu_function),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .busy(busy), .result_valid(result_valid), .result(result)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, r;
    sa = a;
    sb = b;
    case (op)
      ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_REMU: return (b == 0) ? a : a % b;
      ALU_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == SMIN && b == 32'hFFFF_FFFF) return SMIN;
        r = sa / sb;
        return r;
      end
      default: begin
        if (b == 0) return a;
        if (a == SMIN && b == 32'hFFFF_FFFF) return 32'h0;
        r = sa % sb;
        return r;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 1;
    if ((op == ALU_DIV || op == ALU_REM) && a == SMIN && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // Called just after a falling edge while idle; start is sampled at the next rising edge.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    logic [31:0] exp_res;
    int exp_lat, n;
    bit busy_ok;
    exp_res = ref_result(op, a, b);
    exp_lat = ref_latency(op, a, b);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy_before_start: got %b want 0", name, busy);
    end
    start = 1'b1; alu_function = op; operand_a = a; operand_b = b;
    @(negedge clock);
    start = 1'b0; operand_a = $urandom; operand_b = $urandom;
    n = 1;
    busy_ok = 1'b1;
    while (result_valid !== 1'b1 && n < XLEN + 8) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clock);
      n++;
    end
    n_cmp++;
    if (!busy_ok || busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s busy_during_op: got low cycle want high through DONE", name);
    end
    n_cmp++;
    if (n != exp_lat || result_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s valid_latency: got %0d (valid=%b) want %0d", name, n, result_valid, exp_lat);
    end
    n_cmp++;
    if (result !== exp_res) begin
      n_err++;
      $display("FAIL %s result: a=%h b=%h got %h want %h", name, a, b, result, exp_res);
    end
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result !== exp_res) begin
      n_err++;
      $display("FAIL %s after_done: busy=%b valid=%b result=%h want 0 0 %h", name, busy, result_valid, result, exp_res);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; alu_function = ALU_ADD;
    operand_a = '0; operand_b = '0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result !== '0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b valid=%b result=%h want 0 0 0", busy, result_valid, result);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_directed();
    run_op(ALU_DIVU, 100, 7, "divu_100_7");
    run_op(ALU_REMU, 100, 7, "remu_100_7");
    run_op(ALU_DIV, 32'hFFFF_FFF9, 2, "div_m7_2");
    run_op(ALU_REM, 32'hFFFF_FFF9, 2, "rem_m7_2");
    run_op(ALU_REM, 7, 32'hFFFF_FFFE, "rem_7_m2");
    run_op(ALU_DIV, 5, 0, "div_by_zero");
    run_op(ALU_REMU, 5, 0, "remu_by_zero");
    run_op(ALU_DIV, SMIN, 32'hFFFF_FFFF, "div_overflow");
    run_op(ALU_REM, SMIN, 32'hFFFF_FFFF, "rem_overflow");
  endtask

  task automatic test_flush_calc();
    logic [31:0] prev;
    bit seen_valid;
    run_op(ALU_DIVU, 1000, 3, "pre_flush");
    prev = result;
    start = 1'b1; alu_function = ALU_DIVU; operand_a = $urandom; operand_b = 32'd5;
    @(negedge clock);                      // cycle T+1
    start = 1'b0;
    seen_valid = 1'b0;
    repeat (9) begin
      if (result_valid === 1'b1) seen_valid = 1'b1;
      @(negedge clock);
    end                                    // now in cycle T+10
    flush = 1'b1;
    @(negedge clock);                      // cycle T+11
    flush = 1'b0;
    if (result_valid === 1'b1) seen_valid = 1'b1;
    n_cmp++;
    if (busy !== 1'b0 || seen_valid) begin
      n_err++;
      $display("FAIL flush_calc_state: busy=%b valid_seen=%b want 0 0", busy, seen_valid);
    end
    n_cmp++;
    if (result !== prev) begin
      n_err++;
      $display("FAIL flush_calc_result: got %h want %h", result, prev);
    end
    run_op(ALU_DIVU, 9, 3, "after_flush_divu_9_3");
  endtask

  task automatic test_flush_idle_done();
    logic [31:0] prev;
    prev = result;
    flush = 1'b1; start = 1'b1; alu_function = ALU_DIVU; operand_a = 50; operand_b = 0;
    @(negedge clock);
    start = 1'b0; flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || result !== prev) begin
      n_err++;
      $display("FAIL flush_idle_blocks_start: busy=%b result=%h want 0 %h", busy, result, prev);
    end
    start = 1'b1; alu_function = ALU_DIV; operand_a = 5; operand_b = 0;
    @(negedge clock);
    start = 1'b0; flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || result !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL flush_done: busy=%b result=%h want 0 ffffffff", busy, result);
    end
    @(negedge clock);
  endtask

  task automatic test_start_mask();
    logic [31:0] a, b, exp_res;
    int n;
    a = $urandom; b = $urandom_range(1, 65535);
    exp_res = a / b;
    start = 1'b1; alu_function = ALU_DIVU; operand_a = a; operand_b = b;
    @(negedge clock);
    n = 1;
    repeat (20) begin
      alu_function = ALU_REM; operand_a = $urandom; operand_b = $urandom;
      @(negedge clock);
      n++;
    end
    start = 1'b0;
    while (result_valid !== 1'b1 && n < XLEN + 8) begin
      @(negedge clock);
      n++;
    end
    n_cmp++;
    if (n != XLEN + 1 || result !== exp_res) begin
      n_err++;
      $display("FAIL start_mask: latency %0d result %h want %0d %h", n, result, XLEN + 1, exp_res);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_calc();
    start = 1'b1; alu_function = ALU_DIVU; operand_a = $urandom; operand_b = 32'd3;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result !== '0) begin
      n_err++;
      $display("FAIL async_reset: busy=%b valid=%b result=%h want 0 0 0", busy, result_valid, result);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run_op(ALU_DIVU, 32'hFFFF_FFFF, 1, "divu_max_1");
  endtask

  task automatic test_ignored_code();
    logic [31:0] prev;
    prev = result;
    start = 1'b1; alu_function = ALU_ADD; operand_a = 12; operand_b = 0;
    @(negedge clock);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result !== prev) begin
      n_err++;
      $display("FAIL ignored_add: busy=%b valid=%b result=%h want 0 0 %h", busy, result_valid, result, prev);
    end
  endtask

  task automatic test_random();
    logic [4:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: op = ALU_DIV;
        1: op = ALU_DIVU;
        2: op = ALU_REM;
        default: op = ALU_REMU;
      endcase
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: begin a = SMIN; b = 32'hFFFF_FFFF; end
        2: b = 1;
        3: b = $urandom_range(1, 255);
        4: b = -$urandom_range(1, 255);
        default: ;
      endcase
      run_op(op, a, b, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush_calc();
    test_flush_idle_done();
    test_start_mask();
    test_reset_mid_calc();
    test_ignored_code();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/divider_sequencer.md
# divider_sequencer

Multi-cycle sequencer for the M-extension divide/remainder operations (`ALU_DIV`, `ALU_DIVU`, `ALU_REM`, `ALU_REMU`) selected by the ALU controller.

- Runs a radix-2 restoring division, one quotient bit per clock.
- Handles the RISC-V special cases: divide-by-zero and signed overflow.
- Presents a start/busy/result_valid handshake so the core can stall while the division runs.
- Sits beside the single-cycle ALU in the execute stage; the core writes back `result` when `result_valid` pulses.

## Interface

Parameters:
- `XLEN`, default 32: operand and result width.

Ports:
- `clock`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous reset, active high.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `alu_function`  in  5  operation code from the ALU controller, sampled with `start`.
- `operand_a`  in  XLEN  dividend, sampled with `start`.
- `operand_b`  in  XLEN  divisor, sampled with `start`.
- `flush`  in  1  abort the current operation; priority over `start`.
- `busy`  out  1  high whenever the state is not IDLE.
- `result_valid`  out  1  one-cycle pulse; high only in the DONE state.
- `result`  out  XLEN  quotient or remainder; held stable from DONE until the next accepted `start`.

## Operation

State machine: IDLE, CALC, DONE.

**IDLE**
- `start` is accepted only if `alu_function` is one of the four divide codes. Any other code is ignored: no state change, `result` unchanged.
- On acceptance, latch the operation type and the operands.
- If the divisor is zero, or the op is signed overflow (DIV/REM with dividend = -2^(XLEN-1) and divisor = -1), go directly to DONE with the special result:
  - div-by-zero: DIV/DIVU return all ones; REM/REMU return the dividend.
  - overflow: DIV returns -2^(XLEN-1); REM returns 0.
- Otherwise load the magnitudes into the datapath, clear the remainder, set the iteration counter to XLEN-1 and go to CALC.
- Magnitudes: absolute values for DIV/REM; raw operands for DIVU/REMU.

**CALC**
- Each cycle:
  - shift {remainder, dividend} left by one;
  - trial-subtract the divisor magnitude using an XLEN+1-bit remainder;
  - if there is no borrow, keep the difference and shift in quotient bit 1, else shift in 0.
- The counter decrements each cycle. When it is 0, the iteration in that cycle is the last one and the next state is DONE.
- The final result is registered into `result` on the transition to DONE:
  - DIV: quotient, negated if the operand signs differ;
  - REM: remainder, negated if the dividend is negative;
  - DIVU / REMU: unsigned quotient / remainder.

**DONE**
- `result_valid` = 1 and `busy` = 1.
- Unconditional transition to IDLE next edge.

**Flush**
- `flush` in CALC: next state IDLE; no `result_valid` is produced; `result` is not updated.
- `flush` in DONE: does not suppress that cycle's `result_valid`; next state IDLE as normal.
- `flush` in IDLE: blocks `start` in the same cycle.

**Other rules**
- `start` while `busy` is ignored; latched operands cannot be modified mid-operation.
- Reset (asynchronous) forces: state IDLE, `busy` 0, `result_valid` 0, `result` 0, counter 0, datapath registers 0. It takes effect immediately, including mid-CALC.

## Timing

- `start` sampled at the edge ending cycle T.
- Normal path:
  - CALC occupies cycles T+1 … T+XLEN;
  - DONE (`result_valid` high) in cycle T+XLEN+1;
  - IDLE in T+XLEN+2, where a new `start` can be accepted (one op per XLEN+2 cycles).
- Special-case path: DONE in cycle T+1; IDLE in T+2.
- `busy` is registered: low in cycle T, high from T+1 through the DONE cycle.
  - The core must assert its stall from `start` in cycle T itself.
- `result` changes only on the edge entering DONE and on reset.

## Test plan

- XLEN=32, DIVU 100/7 started at T: `busy` high T+1..T+33, `result_valid` only in T+33, `result` = 14; then REMU 100/7: `result` = 2.
- DIV 0xFFFFFFF9 (-7) / 2: `result` = 0xFFFFFFFD (-3). REM same operands: `result` = 0xFFFFFFFF (-1). REM 7 / 0xFFFFFFFE (-2): `result` = 1.
- Special cases:
  - DIV 5/0: `result_valid` in T+1, `result` = 0xFFFFFFFF.
  - REMU 5/0: `result` = 5.
  - DIV 0x80000000/0xFFFFFFFF: `result` = 0x80000000, valid in T+1.
  - REM same operands: `result` = 0.
- Flush and `start` masking:
  - `flush` in cycle T+10 of a DIVU: no `result_valid` ever; `busy` low in T+11; `result` keeps its previous value.
  - A `start` (DIVU 9/3) in T+11 yields 3 in T+11+33.
  - `start` pulses during CALC have no effect.
- Reset and ignored codes:
  - `reset` asserted asynchronously mid-CALC: `busy`, `result_valid`, `result` go to 0 without a clock edge.
  - After release, DIVU 0xFFFFFFFF/1 gives 0xFFFFFFFF.
  - `start` with `alu_function` = `ALU_ADD` leaves the block in IDLE with `busy` 0.
